// File: rtl/imem_loader_if.sv
// Handshake and memory-write bundle for imem_loader.
interface imem_loader_if;
  logic        start;
  logic [7:0]  len_words;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, len_words, s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );

  modport slave (
    input  start, len_words, s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: assembles little-endian words and writes them.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per session.
module imem_loader #(
  parameter int unsigned DEPTH_BYTES = 32
) (
  input logic        clk,
  input logic        rst_n,
  imem_loader_if.slave bus
);
  localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / 4;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR, CHECK} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;
`endif

  state_t      state, next;
  logic [1:0]  byte_idx;
  logic [7:0]  word_idx;
  logic [7:0]  len_q;
  logic [31:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        launch, accept, last, len_ok;
  logic        s_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  assign len_ok = (bus.len_words != 8'd0) && (32'(bus.len_words) <= DEPTH_WORDS);
  assign last   = ({1'b0, word_idx} + 9'd1) == {1'b0, len_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next      = state;
    launch    = 1'b0;
    accept    = 1'b0;
    s_ready   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        done = (state == DONE);
        err  = (state == ERR);
        if (bus.start) begin
          if (len_ok) begin
            next   = LOAD;
            launch = 1'b1;
          end else begin
            next = ERR;
          end
        end
      end
      LOAD: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (bus.s_valid) begin
          accept = 1'b1;
          if (byte_idx == 2'd3) next = WRITE;
        end
      end
      WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {22'd0, word_idx, 2'b00};
        mem_wdata = word;
`ifdef IMEM_LOADER_CHECKSUM_EN
        next = last ? CHECK : LOAD;
`else
        next = last ? DONE : LOAD;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (bus.s_valid) next = (bus.s_data == csum) ? DONE : ERR;
      end
`endif
      default: next = IDLE;
    endcase
  end

  // Word index only advances when another word follows, so it never wraps past len_q-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      word_idx <= '0;
      len_q    <= '0;
      word     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      if (launch) begin
        byte_idx <= '0;
        word_idx <= '0;
        len_q    <= bus.len_words;
        word     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      if (accept) begin
        word[{byte_idx, 3'b000} +: 8] <= bus.s_data;
        byte_idx                      <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum                          <= csum ^ bus.s_data;
`endif
      end
      if (state == WRITE && !last) word_idx <= word_idx + 8'd1;
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by stimulus, popped by a monitor.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if bus ();
  imem_loader #(.DEPTH_BYTES(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  pl[$];
  logic [31:0] ew[$];
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every write must match the head of the queue; idle bus must read zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", bus.mem_addr, e.addr);
          check("write_data", bus.mem_wdata, e.data);
        end
      end else begin
        check("idle_addr", bus.mem_addr, 32'h0);
        check("idle_data", bus.mem_wdata, 32'h0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [7:0] len);
    bus.start     = 1'b1;
    bus.len_words = len;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_wait", {31'd0, bus.s_ready}, 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_end(input bit exp_done, input bit exp_err);
    int unsigned n = 0;
    while (!(bus.done || bus.err) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done", {31'd0, bus.done}, {31'd0, exp_done});
    check("err",  {31'd0, bus.err},  {31'd0, exp_err});
    check("busy_end", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic session(input logic [7:0] len, input bit toggle, input bit mid_start, input bit bad);
    logic [7:0] x = 8'h00;
    pulse_start(len);
    for (int w = 0; w < int'(len); w++) begin
      exp_q.push_back('{addr: 32'(w * 4), data: ew[w]});
      for (int k = 0; k < 4; k++) begin
        if (toggle) @(negedge clk);
        if (mid_start && w == 0 && k == 2) pulse_start(8'd1);
        send_byte(pl[4 * w + k]);
        x = x ^ pl[4 * w + k];
      end
      check("we_latency", {31'd0, bus.mem_we}, 32'd1);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad ? (x ^ 8'h01) : x);
`endif
    wait_end(!bad, bad);
  endtask

  task automatic check_reset_outputs();
    check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("rst_mem_we",  {31'd0, bus.mem_we},  32'd0);
    check("rst_addr",    bus.mem_addr,         32'd0);
    check("rst_wdata",   bus.mem_wdata,        32'd0);
    check("rst_busy",    {31'd0, bus.busy},    32'd0);
    check("rst_done",    {31'd0, bus.done},    32'd0);
    check("rst_err",     {31'd0, bus.err},     32'd0);
  endtask

  task automatic bad_len(input logic [7:0] len);
    pulse_start(len);
    check("badlen_err",  {31'd0, bus.err},    32'd1);
    check("badlen_busy", {31'd0, bus.busy},   32'd0);
    check("badlen_done", {31'd0, bus.done},   32'd0);
    check("badlen_we",   {31'd0, bus.mem_we}, 32'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len_words = 8'd0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Single word
    pl = '{8'h13, 8'h81, 8'h10, 8'h00};
    ew = '{32'h00108113};
    session(8'd1, 1'b0, 1'b0, 1'b0);

    // Full depth with s_valid toggling
    pl.delete();
    for (int i = 0; i < 32; i++) pl.push_back(8'(i));
    ew = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
           32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    session(8'd8, 1'b1, 1'b0, 1'b0);

    // Illegal lengths
    bad_len(8'd9);
    bad_len(8'd0);
    repeat (3) @(negedge clk);

    // Reset after two bytes of word 1
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    pulse_start(8'd2);
    exp_q.push_back('{addr: 32'h0, data: 32'h44332211});
    for (int k = 0; k < 6; k++) send_byte(pl[k]);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    pl = '{8'h23, 8'hA4, 8'h64, 8'h00};
    ew = '{32'h0064A423};
    session(8'd1, 1'b0, 1'b0, 1'b0);

    // start pulsed mid-load must be ignored
    pl = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01};
    ew = '{32'hDEADBEEF, 32'h01234567};
    session(8'd2, 1'b0, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pl = '{8'h01, 8'h02, 8'h04, 8'h08};
    ew = '{32'h08040201};
    session(8'd1, 1'b0, 1'b0, 1'b0);
    session(8'd1, 1'b0, 1'b0, 1'b1);
`endif

    repeat (4) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_BYTES, default 32, instruction memory size in bytes; SHALL be a multiple of 4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; begins a load session.
REQ-005 len_words  input  8  number of 32-bit words to load; sampled on start.
REQ-006 s_valid  input  1  byte-stream data valid.
REQ-007 s_data  input  8  byte-stream payload byte.
REQ-008 s_ready  output  1  loader can accept a byte this cycle.
REQ-009 mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-010 mem_addr  output  32  byte address of written word, always word-aligned.
REQ-011 mem_wdata  output  32  word to write, little-endian assembled.
REQ-012 busy  output  1  session in progress.
REQ-013 done  output  1  session completed successfully; held until next start.
REQ-014 err  output  1  session failed; held until next start.

Function
REQ-015 States SHALL be IDLE, LOAD, WRITE, DONE, ERR, plus CHECK when checksum is enabled.
REQ-016 IDLE/DONE/ERR: start with 1 <= len_words <= DEPTH_BYTES/4 -> LOAD, clear byte index, word index, checksum, done, err.
REQ-017 IDLE/DONE/ERR: start with len_words = 0 or > DEPTH_BYTES/4 -> ERR next cycle; no memory write.
REQ-018 start while busy SHALL be ignored.
REQ-019 LOAD: s_ready=1; byte accepted when s_valid && s_ready; byte k of word (k=0..3) placed in bits [8k+7:8k].
REQ-020 Acceptance of 4th byte -> WRITE on next edge; s_ready=0 in WRITE.
REQ-021 WRITE: mem_we=1 for exactly one cycle, mem_addr = word_index*4, mem_wdata = assembled word.
REQ-022 Write latency: mem_we asserts exactly one cycle after the 4th byte's acceptance edge.
REQ-023 After WRITE: if word_index+1 = len_words -> DONE (or CHECK), else word_index+1 and LOAD.
REQ-024 mem_addr SHALL never exceed DEPTH_BYTES-4; word index SHALL not wrap.
REQ-025 s_valid while s_ready=0 SHALL not be consumed; source holds byte until accepted.
REQ-026 busy=1 in LOAD, WRITE, CHECK; 0 otherwise; mem_we=0 in every state but WRITE.
REQ-027 mem_addr and mem_wdata SHALL be 0 whenever mem_we=0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
REQ-029 Reset mid-session SHALL discard partial word and counters; no write issued after reset deasserts without a new start.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN defined: after last WRITE enter CHECK, s_ready=1, accept one byte; equal to XOR of all payload bytes -> DONE, else ERR.
REQ-031 Macro undefined: no CHECK state, no checksum logic; last WRITE -> DONE directly.

Verification
REQ-032 start, len_words=1, bytes 0x13,0x81,0x10,0x00 -> one mem_we, mem_addr=0x0, mem_wdata=0x00108113, then done=1.
REQ-033 len_words=8, 32 bytes with s_valid toggling every other cycle -> 8 writes at addresses 0x00..0x1C ascending, done=1, no byte lost.
REQ-034 start with len_words=9 (DEPTH_BYTES=32) or 0 -> err=1 next cycle, mem_we never asserts, busy=0.
REQ-035 rst_n low after 2 bytes of word 1, release, then new start len_words=1 with 0x23,0xA4,0x64,0x00 -> single write mem_wdata=0x0064A423 at 0x0.
REQ-036 With IMEM_LOADER_CHECKSUM_EN: len_words=1, bytes 0x01,0x02,0x04,0x08, checksum 0x0F -> done=1; checksum 0x0E -> err=1, write at 0x0 still issued.
REQ-037 start pulsed during LOAD -> ignored; session completes with original len_words.
